serial_id_reader: RTL and testbench
===================================

SERIAL_ID_READER -- requirements
Module: serial_id_reader

Interface
REQ-001 Parameter ID_WIDTH, default 57, number of ID bits read; legal range 1..64.
REQ-002 Parameter HALF_DIV, default 2, clk cycles per id_clk half-period; legal range >=1.
REQ-003 Parameter READ_ON_RESET, default 1, starts a read automatically after reset release when 1.
REQ-004 Parameter CHECK_EN, default 0, enables comparison against EXPECTED_ID when 1.
REQ-005 Parameter EXPECTED_ID, default all-zero ID_WIDTH value, golden ID for the comparison.
REQ-006 clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request a new read; sampled every clk edge.
REQ-009 id_clk  output  1  registered serial clock to the ID primitive, clk/(2*HALF_DIV).
REQ-010 id_read  output  1  primitive load strobe, active high.
REQ-011 id_shift  output  1  primitive shift enable, active high.
REQ-012 id_dout  input  1  serial data from the primitive, MSB first.
REQ-013 id  output  ID_WIDTH  last completely read ID.
REQ-014 valid  output  1  id holds a complete read.
REQ-015 busy  output  1  read in progress.
REQ-016 match  output  1  valid and id equals EXPECTED_ID; constant 0 when CHECK_EN=0.

Function
REQ-017 States: IDLE, LOAD, SHIFT, all clocked by clk with no derived clock domain.
REQ-018 In IDLE: id_clk held 0, half-period counter held at 0, busy=0.
REQ-019 IDLE->LOAD on an edge with start=1, or on the first edge after reset when READ_ON_RESET=1; at that edge id_read<=1, id_shift<=0, busy<=1, valid<=0.
REQ-020 While busy, id_clk toggles every HALF_DIV clk edges, starting with a rising transition.
REQ-021 Edge numbering: the start-accepting edge is edge 0; id_clk rises at edge H and falls at edge 2H, with H=HALF_DIV.
REQ-022 id_read and id_shift change only on id_clk falling edges; the primitive sees them stable around every rising edge.
REQ-023 At each id_clk falling edge while busy: id_dout shifts into the internal register LSB-in (shreg <= {shreg[W-2:0], id_dout}) and the bit count increments.
REQ-024 At the first falling edge (edge 2H): LOAD->SHIFT, id_read<=0, id_shift<=1.
REQ-025 The Nth sample is taken at edge 2H*N, for N = 1..ID_WIDTH.
REQ-026 At edge 2H*ID_WIDTH: id <= completed register, valid<=1, busy<=0, id_shift<=0, id_clk 0, state->IDLE.
REQ-027 During a read, id keeps its previous value and updates only at completion.
REQ-028 start while busy, including on the completion edge, is ignored; it is not queued.
REQ-029 start in IDLE with valid=1 begins a new read and drops valid on the same edge.
REQ-030 match is registered and updates on the completion edge; it is cleared whenever valid is cleared.
REQ-031 Bit counter width is clog2(ID_WIDTH+1); the half-period counter wraps from HALF_DIV-1 to 0.
REQ-032 ID_WIDTH=1: exactly one sample, and completion occurs on the same edge as the LOAD->SHIFT transition.

Reset
REQ-033 rst_n low asynchronously forces state IDLE, all counters 0, id_clk=0, id_read=1, id_shift=0, id=0, valid=0, busy=0, match=0.
REQ-034 Reset mid-read abandons the read with no partial id update; the restart rule of REQ-019 applies after release.
REQ-035 rst_n release is synchronised by the integrating top; the block requires no extra deassertion logic.

Structure
REQ-036 Shared package holds the state enumeration (IDLE=0, LOAD=1, SHIFT=2, 2-bit) and default parameter constants.
REQ-037 One sub-module, id_clk_gen, holds the half-period counter, the id_clk register and the rise/fall tick pulses; its enable is busy.
REQ-038 Elaboration-time checks reject out-of-range ID_WIDTH or HALF_DIV.

Verification
REQ-039 ID_WIDTH=8, HALF_DIV=2, primitive model loaded with 0xA5, start at edge 0 -> id_read high until edge 4; id=0xA5, valid=1 at edge 32; busy low at edge 32.
REQ-040 READ_ON_RESET=1, model 0x3C -> read starts on the first edge after rst_n release; id=0x3C, valid=1 32 edges later.
REQ-041 start pulsed at edges 10 and 32 during a read -> both ignored; exactly one completion at edge 32; id_clk low afterward.
REQ-042 rst_n asserted at edge 20 of a read of 0xFF over previous id 0x11 -> all outputs at reset values immediately; id=0, valid=0, no completion.
REQ-043 CHECK_EN=1, EXPECTED_ID=0xA5 -> model 0xA5 gives match=1; a re-read of 0x5A gives match=0 at the start edge and stays 0 after completion.
REQ-044 ID_WIDTH=1, HALF_DIV=1, model bit 1 -> id=1, valid=1 at edge 2.

Source files
------------

// File: rtl/serial_id_reader_pkg.sv
// Shared types and default constants for the serial ID reader.
package serial_id_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int DEF_ID_WIDTH      = 57;
  localparam int DEF_HALF_DIV      = 2;
  localparam int DEF_READ_ON_RESET = 1;
  localparam int DEF_CHECK_EN      = 0;

endpackage

// File: rtl/serial_id_reader_id_clk_gen.sv
// Serial clock generator: id_clk toggles every HALF_DIV enabled clk edges, first edge rising.
module id_clk_gen
  import serial_id_reader_pkg::*;
#(
  parameter int HALF_DIV = DEF_HALF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic id_clk,
  output logic fall
);

  localparam int HC_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [HC_W-1:0] cnt;
  logic            tick;
  logic            rise;

  assign tick = en && (cnt == HC_W'(HALF_DIV - 1));
  assign rise = tick && !id_clk;
  assign fall = tick && id_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      id_clk <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      id_clk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + HC_W'(1);
      if (rise)
        id_clk <= 1'b1;
      else if (fall)
        id_clk <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_id_reader.sv
// Reads an ID serially (MSB first) from a load/shift primitive; samples on id_clk falling edges.
// States: IDLE = waiting for start | LOAD = id_read asserted, first bit pending | SHIFT = shifting remaining bits
module serial_id_reader
  import serial_id_reader_pkg::*;
#(
  parameter int                  ID_WIDTH      = DEF_ID_WIDTH,
  parameter int                  HALF_DIV      = DEF_HALF_DIV,
  parameter int                  READ_ON_RESET = DEF_READ_ON_RESET,
  parameter int                  CHECK_EN      = DEF_CHECK_EN,
  parameter logic [ID_WIDTH-1:0] EXPECTED_ID   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                id_clk,
  output logic                id_read,
  output logic                id_shift,
  input  logic                id_dout,
  output logic [ID_WIDTH-1:0] id,
  output logic                valid,
  output logic                busy,
  output logic                match
);

  localparam int CNT_W = $clog2(ID_WIDTH + 1);

  if (ID_WIDTH < 1 || ID_WIDTH > 64) begin : g_bad_id_width
    $error("serial_id_reader: ID_WIDTH must be in 1..64");
  end
  if (HALF_DIV < 1) begin : g_bad_half_div
    $error("serial_id_reader: HALF_DIV must be >= 1");
  end

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] shreg, shreg_nxt, shifted, id_nxt;
  logic [CNT_W-1:0]    bits, bits_nxt;
  logic                id_read_nxt, id_shift_nxt, busy_nxt, valid_nxt, match_nxt;
  logic                boot;
  logic                fall;

  id_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (busy),
    .id_clk (id_clk),
    .fall   (fall)
  );

  assign shifted = (shreg << 1) | ID_WIDTH'(id_dout);

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bits_nxt     = bits;
    id_nxt       = id;
    id_read_nxt  = id_read;
    id_shift_nxt = id_shift;
    busy_nxt     = busy;
    valid_nxt    = valid;
    match_nxt    = match;
    case (state)
      ST_IDLE: begin
        if (start || boot) begin
          state_nxt    = ST_LOAD;
          bits_nxt     = '0;
          id_read_nxt  = 1'b1;
          id_shift_nxt = 1'b0;
          busy_nxt     = 1'b1;
          valid_nxt    = 1'b0;
          match_nxt    = 1'b0;
        end
      end
      ST_LOAD, ST_SHIFT: begin
        if (fall) begin
          shreg_nxt = shifted;
          bits_nxt  = bits + CNT_W'(1);
          id_read_nxt = 1'b0;
          // A one-bit ID completes on the same edge that would enter SHIFT.
          if (bits == CNT_W'(ID_WIDTH - 1)) begin
            state_nxt    = ST_IDLE;
            id_nxt       = shifted;
            id_shift_nxt = 1'b0;
            busy_nxt     = 1'b0;
            valid_nxt    = 1'b1;
            match_nxt    = (CHECK_EN != 0) && (shifted == EXPECTED_ID);
          end else begin
            state_nxt    = ST_SHIFT;
            id_shift_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bits     <= '0;
      id       <= '0;
      id_read  <= 1'b1;
      id_shift <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      match    <= 1'b0;
      boot     <= (READ_ON_RESET != 0);
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bits     <= bits_nxt;
      id       <= id_nxt;
      id_read  <= id_read_nxt;
      id_shift <= id_shift_nxt;
      busy     <= busy_nxt;
      valid    <= valid_nxt;
      match    <= match_nxt;
      boot     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_id_reader.sv
// Directed bench for serial_id_reader: 8-bit checked instance and a 1-bit instance with ID primitive models.
module tb_serial_id_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       id_clk_a, id_read_a, id_shift_a, id_dout_a, valid_a, busy_a, match_a;
  logic [7:0] id_a;
  logic       id_clk_b, id_read_b, id_shift_b, id_dout_b, valid_b, busy_b, match_b;
  logic [0:0] id_b;

  logic [7:0] mval_a, mreg_a;
  logic       mval_b, mreg_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_id_reader #(
    .ID_WIDTH(8), .HALF_DIV(2), .READ_ON_RESET(1), .CHECK_EN(1), .EXPECTED_ID(8'hA5)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .id_clk(id_clk_a), .id_read(id_read_a),
    .id_shift(id_shift_a), .id_dout(id_dout_a), .id(id_a), .valid(valid_a),
    .busy(busy_a), .match(match_a)
  );

  serial_id_reader #(
    .ID_WIDTH(1), .HALF_DIV(1), .READ_ON_RESET(0), .CHECK_EN(0), .EXPECTED_ID(1'b0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .id_clk(id_clk_b), .id_read(id_read_b),
    .id_shift(id_shift_b), .id_dout(id_dout_b), .id(id_b), .valid(valid_b),
    .busy(busy_b), .match(match_b)
  );

  // ID primitive models: load on id_clk rise with id_read, shift on rise with id_shift.
  always @(posedge id_clk_a or negedge rst_n)
    if (!rst_n)          mreg_a <= '0;
    else if (id_read_a)  mreg_a <= mval_a;
    else if (id_shift_a) mreg_a <= mreg_a << 1;
  assign id_dout_a = mreg_a[7];

  always @(posedge id_clk_b or negedge rst_n)
    if (!rst_n)          mreg_b <= 1'b0;
    else if (id_read_b)  mreg_b <= mval_b;
    else if (id_shift_b) mreg_b <= 1'b0;
  assign id_dout_b = mreg_b;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic sa, input logic sb);
    @(negedge clk);
    start_a = sa;
    start_b = sb;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mval_a  = 8'h3C;
    mval_b  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_id_read", id_read_a, 1'b1);
    check_val("rst_busy",    busy_a,    1'b0);
    check_val("rst_valid",   valid_a,   1'b0);
    check_val("rst_id",      id_a,      8'h00);
    check_val("rst_id_clk",  id_clk_a,  1'b0);
    check_val("rst_shift",   id_shift_a, 1'b0);
    check_val("rst_match",   match_a,   1'b0);

    // boot read on first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("boot_busy",     busy_a,   1'b1);
    check_val("boot_id_clk",   id_clk_a, 1'b0);
    check_val("b_no_autoread", busy_b,   1'b0);
    repeat (31) step(1'b0, 1'b0);
    check_val("boot_e31_valid", valid_a, 1'b0);
    step(1'b0, 1'b0);
    check_val("boot_id",    id_a,    8'h3C);
    check_val("boot_valid", valid_a, 1'b1);
    check_val("boot_busy0", busy_a,  1'b0);
    check_val("boot_match", match_a, 1'b0);

    // read 0xA5 with matching golden ID
    mval_a = 8'hA5;
    step(1'b1, 1'b0);
    check_val("a5_e0_busy",  busy_a,    1'b1);
    check_val("a5_e0_read",  id_read_a, 1'b1);
    check_val("a5_e0_valid", valid_a,   1'b0);
    for (int e = 1; e <= 32; e++) begin
      step(1'b0, 1'b0);
      if (e == 1) check_val("a5_e1_id_clk", id_clk_a, 1'b0);
      if (e == 2) check_val("a5_e2_id_clk", id_clk_a, 1'b1);
      if (e == 3) check_val("a5_e3_read",   id_read_a, 1'b1);
      if (e == 4) begin
        check_val("a5_e4_read",   id_read_a,  1'b0);
        check_val("a5_e4_shift",  id_shift_a, 1'b1);
        check_val("a5_e4_id_clk", id_clk_a,   1'b0);
      end
      if (e == 16) check_val("a5_e16_id_old", id_a, 8'h3C);
      if (e == 31) check_val("a5_e31_valid",  valid_a, 1'b0);
    end
    check_val("a5_id",     id_a,       8'hA5);
    check_val("a5_valid",  valid_a,    1'b1);
    check_val("a5_busy",   busy_a,     1'b0);
    check_val("a5_match",  match_a,    1'b1);
    check_val("a5_shift",  id_shift_a, 1'b0);
    check_val("a5_id_clk", id_clk_a,   1'b0);

    // re-read 0x5A with start pulses during the read
    mval_a = 8'h5A;
    step(1'b1, 1'b0);
    check_val("5a_e0_valid", valid_a, 1'b0);
    check_val("5a_e0_match", match_a, 1'b0);
    for (int e = 1; e <= 32; e++) begin
      step((e == 10) || (e == 32), 1'b0);
      if (e == 10) check_val("5a_e10_busy",  busy_a, 1'b1);
      if (e == 20) check_val("5a_e20_id_old", id_a, 8'hA5);
    end
    check_val("5a_id",    id_a,    8'h5A);
    check_val("5a_valid", valid_a, 1'b1);
    check_val("5a_match", match_a, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check_val("5a_no_requeue", busy_a,   1'b0);
    check_val("5a_id_clk_low", id_clk_a, 1'b0);
    check_val("5a_match_hold", match_a,  1'b0);

    // one-bit, HALF_DIV=1 instance
    step(1'b0, 1'b1);
    check_val("w1_e0_busy", busy_b,    1'b1);
    check_val("w1_e0_read", id_read_b, 1'b1);
    step(1'b0, 1'b0);
    check_val("w1_e1_id_clk", id_clk_b, 1'b1);
    check_val("w1_e1_valid",  valid_b,  1'b0);
    step(1'b0, 1'b0);
    check_val("w1_id",     id_b,       1'b1);
    check_val("w1_valid",  valid_b,    1'b1);
    check_val("w1_busy",   busy_b,     1'b0);
    check_val("w1_match",  match_b,    1'b0);
    check_val("w1_read",   id_read_b,  1'b0);
    check_val("w1_shift",  id_shift_b, 1'b0);

    // read 0x11, then abandon a read of 0xFF with reset at edge 20
    mval_a = 8'h11;
    step(1'b1, 1'b0);
    repeat (32) step(1'b0, 1'b0);
    check_val("11_id", id_a, 8'h11);
    mval_a = 8'hFF;
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_id",     id_a,       8'h00);
    check_val("mid_rst_valid",  valid_a,    1'b0);
    check_val("mid_rst_busy",   busy_a,     1'b0);
    check_val("mid_rst_read",   id_read_a,  1'b1);
    check_val("mid_rst_shift",  id_shift_a, 1'b0);
    check_val("mid_rst_id_clk", id_clk_a,   1'b0);
    mval_a = 8'h96;
    repeat (40) @(posedge clk);
    #1;
    check_val("held_rst_id",    id_a,    8'h00);
    check_val("held_rst_valid", valid_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("reboot_busy", busy_a, 1'b1);
    repeat (32) step(1'b0, 1'b0);
    check_val("reboot_id",    id_a,    8'h96);
    check_val("reboot_valid", valid_a, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
